// File: rtl/mic_pkg.sv
// Shared constants, FSM encoding and width helper for the microphone delay-and-sum stage.
package mic_pkg;

   localparam int MIC_CHANNELS = 6;
   localparam int MIC_WIDTH    = 16;
   localparam int MIC_DEPTH    = 64;

   typedef enum logic [1:0] {
      IDLE,
      WRITE,
      READ,
      DONE
   } state_t;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/mic_sample_ram.sv
// Single-port synchronous sample RAM, read-first, registered read data (1-cycle latency).
module mic_sample_ram #(
   parameter int WIDTH     = 16,
   parameter int ADDR_BITS = 9
) (
   input  logic                 clk,
   input  logic                 we,
   input  logic [ADDR_BITS-1:0] addr,
   input  logic [WIDTH-1:0]     wdata,
   output logic [WIDTH-1:0]     rdata
);

   logic [WIDTH-1:0] mem [2**ADDR_BITS];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
   end

endmodule

// File: rtl/mic_delay_sum.sv
// Delay-and-sum: per frame, store all channels, read each back with its own frame delay, sum them.
// Output 2*CHANNELS+2 cycles after in_valid; in_valid while busy is dropped and flags overrun.
module mic_delay_sum
   import mic_pkg::*;
#(
   parameter int CHANNELS = MIC_CHANNELS,
   parameter int WIDTH    = MIC_WIDTH,
   parameter int DEPTH    = MIC_DEPTH,
   parameter int DBITS    = clog2(DEPTH),
   localparam int SUM_WIDTH = WIDTH + clog2(CHANNELS)
) (
   input  logic                      CLK,
   input  logic                      RST_N,
   input  logic                      in_valid,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   input  logic                      cfg_we,
   input  logic [3:0]                cfg_chan,
   input  logic [DBITS-1:0]          cfg_delay,
   output logic                      out_valid,
   output logic [CHANNELS*WIDTH-1:0] out_data,
   output logic [SUM_WIDTH-1:0]      out_sum,
   output logic                      busy,
   output logic                      overrun
);

   localparam int CHB   = (CHANNELS > 1) ? clog2(CHANNELS) : 1;
   localparam int CBITS = clog2(CHANNELS + 1);
   localparam int ABITS = CHB + DBITS;
   localparam logic [CBITS-1:0] LAST_WR = CBITS'(CHANNELS - 1);
   localparam logic [CBITS-1:0] LAST_RD = CBITS'(CHANNELS);
   localparam logic [DBITS:0]   FULL    = (DBITS + 1)'(DEPTH);
   localparam logic [4:0]       NCHAN   = 5'(CHANNELS);

   state_t state, state_nxt;

   logic [CBITS-1:0]            cnt;
   logic [DBITS-1:0]            wptr;
   logic [DBITS:0]              fill;
   logic [DBITS-1:0]            shadow [CHANNELS];
   logic [DBITS-1:0]            active [CHANNELS];
   logic signed [WIDTH-1:0]     frame [CHANNELS];
   logic signed [WIDTH-1:0]     cap [CHANNELS];
   logic signed [WIDTH-1:0]     cap_nxt [CHANNELS];
   logic signed [SUM_WIDTH-1:0] acc, acc_nxt;

   logic                        rd_pend;
   logic                        rd_ok;
   logic [CHB-1:0]              rd_idx;
   logic signed [WIDTH-1:0]     rd_sample;

   logic                        ram_we;
   logic [ABITS-1:0]            ram_addr;
   logic [WIDTH-1:0]            ram_wdata;
   logic [WIDTH-1:0]            ram_rdata;
   logic [CHB-1:0]              chan_sel;
   logic [DBITS-1:0]            dly_sel;
   logic                        accept;

   assign busy   = (state == WRITE) || (state == READ);
   assign accept = in_valid && ((state == IDLE) || (state == DONE));

   mic_sample_ram #(
      .WIDTH     (WIDTH),
      .ADDR_BITS (ABITS)
   ) u_ram (
      .clk   (CLK),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid) state_nxt = WRITE;
         WRITE:   if (cnt == LAST_WR) state_nxt = READ;
         READ:    if (cnt == LAST_RD) state_nxt = DONE;
         DONE:    state_nxt = in_valid ? WRITE : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // READ runs one extra cycle with no issue so the last sample can be captured.
   always_comb begin
      chan_sel  = cnt[CHB-1:0];
      dly_sel   = '0;
      ram_wdata = '0;
      if (cnt < LAST_RD) dly_sel = active[chan_sel];
      if (state == WRITE) ram_wdata = frame[chan_sel];
      ram_we    = (state == WRITE);
      ram_addr  = {chan_sel, (state == WRITE) ? wptr : wptr - dly_sel};
      rd_sample = rd_ok ? ram_rdata : '0;
      cap_nxt   = cap;
      acc_nxt   = acc;
      if (rd_pend) begin
         cap_nxt[rd_idx] = rd_sample;
         acc_nxt         = acc + SUM_WIDTH'(rd_sample);
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         cnt       <= '0;
         wptr      <= '0;
         fill      <= '0;
         rd_pend   <= 1'b0;
         rd_ok     <= 1'b0;
         rd_idx    <= '0;
         acc       <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sum   <= '0;
         overrun   <= 1'b0;
         for (int k = 0; k < CHANNELS; k++) begin
            shadow[k] <= '0;
            active[k] <= '0;
            frame[k]  <= '0;
            cap[k]    <= '0;
         end
      end else begin
         out_valid <= 1'b0;
         rd_pend   <= 1'b0;
         cap       <= cap_nxt;
         acc       <= acc_nxt;
         if (cfg_we && ({1'b0, cfg_chan} < NCHAN)) shadow[cfg_chan[CHB-1:0]] <= cfg_delay;
         if (in_valid && busy) overrun <= 1'b1;
         case (state)
            WRITE: cnt <= (cnt == LAST_WR) ? '0 : cnt + 1'b1;
            READ: begin
               if (cnt != LAST_RD) begin
                  // A delay reaching past the frames written since reset reads as silence.
                  rd_pend <= 1'b1;
                  rd_idx  <= chan_sel;
                  rd_ok   <= ({1'b0, dly_sel} <= fill);
                  cnt     <= cnt + 1'b1;
               end else begin
                  out_valid <= 1'b1;
                  out_sum   <= acc_nxt;
                  for (int k = 0; k < CHANNELS; k++) out_data[k*WIDTH +: WIDTH] <= cap_nxt[k];
                  cnt <= '0;
               end
            end
            DONE: begin
               wptr <= wptr + 1'b1;
               if (fill != FULL) fill <= fill + 1'b1;
            end
            default: ;
         endcase
         if (accept) begin
            for (int k = 0; k < CHANNELS; k++) frame[k] <= in_data[k*WIDTH +: WIDTH];
            active <= shadow;
            cnt    <= '0;
            acc    <= '0;
         end
      end
   end

endmodule
